fetch_unit: RTL and testbench

Instruction-fetch stage of the multicycle CPU, sitting directly upstream of the instruction memory and downstream of nothing but the control unit. It owns the word-addressed program counter and drives it to IMem. It latches the combinational instruction IMem returns into an instruction register (IR) and presents it to the control unit with a valid/ready handshake. On acceptance it computes the next PC: sequential, taken branch, or jump, or it halts.

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus between the PC/IR logic, the instruction memory and the control unit.
interface fetch_unit_if #(
  parameter int unsigned PC_W = 32
);
  logic [PC_W-1:0] pc_out;
  logic [31:0]     imem_instr;
  logic [31:0]     ir;
  logic [PC_W-1:0] ir_pc;
  logic            ir_valid;
  logic            ir_ready;
  logic [1:0]      next_sel;
  logic            halted;
  logic [PC_W-1:0] instr_cnt;

  modport master (
    output pc_out, ir, ir_pc, ir_valid, halted, instr_cnt,
    input  imem_instr, ir_ready, next_sel
  );

  modport slave (
    input  pc_out, ir, ir_pc, ir_valid, halted, instr_cnt,
    output imem_instr, ir_ready, next_sel
  );
endinterface

// File: rtl/fetch_unit.sv
// Multicycle instruction-fetch stage: owns the PC, latches IMem output into IR,
// hands it to the control unit and selects sequential/branch/jump/halt next PC.
module fetch_unit #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [PC_W-1:0] r_ir_pc;
  logic            r_ir_valid;
  logic            r_halted;
  logic [PC_W-1:0] r_cnt;

  logic [PC_W-1:0] w_seq;
  logic [PC_W-1:0] w_br;
  logic [PC_W-1:0] w_jmp;

  // Targets are relative to the PC the instruction was fetched from; all sums wrap mod 2^PC_W.
  assign w_seq = r_ir_pc + PC_W'(1);
  assign w_br  = w_seq + {{(PC_W-16){r_ir[15]}}, r_ir[15:0]};
  assign w_jmp = {{(PC_W-26){1'b0}}, r_ir[25:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          r_ir       <= bus.imem_instr;
          r_ir_pc    <= r_pc;
          r_ir_valid <= 1'b1;
          r_state    <= VALID;
        end
        VALID: begin
          if (bus.ir_ready) begin
            r_ir_valid <= 1'b0;
            r_cnt      <= r_cnt + PC_W'(1);
            case (bus.next_sel)
              2'b00: begin
                r_pc    <= w_seq;
                r_state <= FETCH;
              end
              2'b01: begin
                r_pc    <= w_br;
                r_state <= FETCH;
              end
              2'b10: begin
                r_pc    <= w_jmp;
                r_state <= FETCH;
              end
              default: begin
                r_halted <= 1'b1;
                r_state  <= HALT;
              end
            endcase
          end
        end
        HALT: begin
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  assign bus.pc_out    = r_pc;
  assign bus.ir        = r_ir;
  assign bus.ir_pc     = r_ir_pc;
  assign bus.ir_valid  = r_ir_valid;
  assign bus.halted    = r_halted;
  assign bus.instr_cnt = r_cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table-driven program walk with a next-PC scoreboard,
// plus stall, halt, PC wrap and asynchronous-reset sequences.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;

  fetch_unit_if #(.PC_W(32)) bus  ();
  fetch_unit_if #(.PC_W(32)) bus2 ();

  fetch_unit #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  fetch_unit #(.PC_W(32), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  always #5 clk = ~clk;

  // IMem model: a few fixed words, otherwise a jump to (pc+12).
  function automatic logic [31:0] imem_f(input logic [31:0] pc);
    logic [25:0] t;
    t = pc[25:0] + 26'd12;
    case (pc)
      32'd6:   imem_f = 32'h8801_FFFD;
      32'd12:  imem_f = 32'h03FF_FFFF;
      32'd19:  imem_f = 32'h85AE_0001;
      32'd21:  imem_f = 32'h0800_001A;
      32'd26:  imem_f = 32'h0400_0000;
      default: imem_f = {6'b110000, t};
    endcase
  endfunction

  assign bus.imem_instr  = imem_f(bus.pc_out);
  assign bus2.imem_instr = imem_f(bus2.pc_out);
  assign bus2.ir_ready   = 1'b1;
  assign bus2.next_sel   = 2'b00;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    int unsigned stall;
    logic [31:0] ir_pc;
    logic [31:0] ir;
    logic [31:0] next_pc;
  } vec_t;

  vec_t        vt [17];
  logic [31:0] sb_q [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Second instance starts at all-ones: its second fetch must be at address 0.
  initial begin
    @(posedge rst_n);
    @(negedge clk);
    chk("wrap_valid", 32'(bus2.ir_valid), 32'd1);
    chk("wrap_ir_pc", bus2.ir_pc, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("wrap_pc", bus2.pc_out, 32'h0000_0000);
    @(negedge clk);
    chk("wrap_ir_pc2", bus2.ir_pc, 32'h0000_0000);
  end

  initial begin
    int unsigned waited;
    logic [31:0] exp_pc;

    vt[0]  = '{2'b00, 0, 32'd0,          32'hC000_000C, 32'd1};
    vt[1]  = '{2'b00, 0, 32'd1,          32'hC000_000D, 32'd2};
    vt[2]  = '{2'b00, 0, 32'd2,          32'hC000_000E, 32'd3};
    vt[3]  = '{2'b00, 0, 32'd3,          32'hC000_000F, 32'd4};
    vt[4]  = '{2'b00, 0, 32'd4,          32'hC000_0010, 32'd5};
    vt[5]  = '{2'b00, 7, 32'd5,          32'hC000_0011, 32'd6};
    vt[6]  = '{2'b01, 0, 32'd6,          32'h8801_FFFD, 32'd4};
    vt[7]  = '{2'b00, 0, 32'd4,          32'hC000_0010, 32'd5};
    vt[8]  = '{2'b00, 0, 32'd5,          32'hC000_0011, 32'd6};
    vt[9]  = '{2'b00, 0, 32'd6,          32'h8801_FFFD, 32'd7};
    vt[10] = '{2'b10, 0, 32'd7,          32'hC000_0013, 32'd19};
    vt[11] = '{2'b01, 0, 32'd19,         32'h85AE_0001, 32'd21};
    vt[12] = '{2'b10, 0, 32'd21,         32'h0800_001A, 32'd26};
    vt[13] = '{2'b10, 0, 32'd26,         32'h0400_0000, 32'd0};
    vt[14] = '{2'b10, 0, 32'd0,          32'hC000_000C, 32'd12};
    vt[15] = '{2'b10, 0, 32'd12,         32'h03FF_FFFF, 32'h03FF_FFFF};
    vt[16] = '{2'b11, 0, 32'h03FF_FFFF,  32'hC000_000B, 32'h03FF_FFFF};

    bus.ir_ready = 1'b0;
    bus.next_sel = 2'b00;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_pc",     bus.pc_out, 32'd0);
    chk("rst_ir",     bus.ir, 32'd0);
    chk("rst_ir_pc",  bus.ir_pc, 32'd0);
    chk("rst_valid",  32'(bus.ir_valid), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_cnt",    bus.instr_cnt, 32'd0);
    chk("rst_pc_wrap", bus2.pc_out, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ir_ready = 1'b1;

    for (int i = 0; i < 17; i++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!bus.ir_valid && waited < 8);
      chk($sformatf("v%0d_cadence", i), waited, 32'd1);
      chk($sformatf("v%0d_ir_pc", i), bus.ir_pc, vt[i].ir_pc);
      chk($sformatf("v%0d_ir", i), bus.ir, vt[i].ir);
      chk($sformatf("v%0d_pc_hold", i), bus.pc_out, vt[i].ir_pc);
      chk($sformatf("v%0d_cnt_pre", i), bus.instr_cnt, 32'(i));
      if (vt[i].stall > 0) begin
        bus.ir_ready = 1'b0;
        bus.next_sel = 2'b11;
        for (int s = 0; s < int'(vt[i].stall); s++) begin
          @(negedge clk);
          chk($sformatf("stall%0d_valid", s), 32'(bus.ir_valid), 32'd1);
          chk($sformatf("stall%0d_ir", s), bus.ir, vt[i].ir);
          chk($sformatf("stall%0d_ir_pc", s), bus.ir_pc, vt[i].ir_pc);
          chk($sformatf("stall%0d_pc", s), bus.pc_out, vt[i].ir_pc);
          chk($sformatf("stall%0d_cnt", s), bus.instr_cnt, 32'(i));
        end
        bus.ir_ready = 1'b1;
      end
      bus.next_sel = vt[i].sel;
      sb_q.push_back(vt[i].next_pc);
      @(negedge clk);
      exp_pc = sb_q.pop_front();
      chk($sformatf("v%0d_next_pc", i), bus.pc_out, exp_pc);
      chk($sformatf("v%0d_cnt", i), bus.instr_cnt, 32'(i + 1));
      chk($sformatf("v%0d_valid_drop", i), 32'(bus.ir_valid), 32'd0);
      chk($sformatf("v%0d_halted", i), 32'(bus.halted), (vt[i].sel == 2'b11) ? 32'd1 : 32'd0);
    end

    // Halted: handshake inputs must have no effect.
    for (int h = 0; h < 6; h++) begin
      bus.ir_ready = h[0];
      bus.next_sel = 2'($urandom_range(3));
      @(negedge clk);
      chk($sformatf("halt%0d_halted", h), 32'(bus.halted), 32'd1);
      chk($sformatf("halt%0d_valid", h), 32'(bus.ir_valid), 32'd0);
      chk($sformatf("halt%0d_pc", h), bus.pc_out, 32'h03FF_FFFF);
      chk($sformatf("halt%0d_cnt", h), bus.instr_cnt, 32'd17);
    end

    // Asynchronous reset out of HALT, between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_halt_halted", 32'(bus.halted), 32'd0);
    chk("arst_halt_pc", bus.pc_out, 32'd0);
    chk("arst_halt_cnt", bus.instr_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ir_ready = 1'b1;
    bus.next_sel = 2'b00;
    @(negedge clk);
    chk("rel1_valid", 32'(bus.ir_valid), 32'd1);
    chk("rel1_ir_pc", bus.ir_pc, 32'd0);
    @(negedge clk);
    bus.ir_ready = 1'b0;
    chk("rel1_next_pc", bus.pc_out, 32'd1);
    @(negedge clk);
    chk("pre_arst_valid", 32'(bus.ir_valid), 32'd1);
    chk("pre_arst_cnt", bus.instr_cnt, 32'd1);

    // Asynchronous reset mid-VALID.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.ir_valid), 32'd0);
    chk("arst_pc", bus.pc_out, 32'd0);
    chk("arst_cnt", bus.instr_cnt, 32'd0);
    chk("arst_ir", bus.ir, 32'd0);
    chk("arst_ir_pc", bus.ir_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel2_valid", 32'(bus.ir_valid), 32'd1);
    chk("rel2_ir_pc", bus.ir_pc, 32'd0);
    chk("rel2_ir", bus.ir, 32'hC000_000C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
